// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for the fetch (F) and load/store (D) memory ports.
// master = fetch/execute control, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output f_req, f_addr,
    input  f_ack, f_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata
  );

  modport slave (
    input  f_req, f_addr,
    output f_ack, f_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port word memory, IDLE->CMD->RESP per access.
// Define MEM_ARB_FETCH_PRIO_EN for fixed fetch priority instead of round-robin.
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave port,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d_nx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              req_any;
  logic              win_d;
  logic              resp;

  wire unused_addr_bits = ^{port.f_addr[31:ADDR_W+2],
                            port.f_addr[1:0],
                            port.d_addr[31:ADDR_W+2],
                            port.d_addr[1:0]};

  assign req_any = port.f_req | port.d_req;
  assign resp    = (state_q == RESP);

`ifdef MEM_ARB_FETCH_PRIO_EN
  always_comb begin
    win_d = 1'b0;
    unique case (1'b1)
      port.f_req:                 win_d = 1'b0;
      !port.f_req && port.d_req:  win_d = 1'b1;
      default:                    win_d = 1'b0;
    endcase
  end
`else
  // Last-grant flag resets to D so that F wins the first contention.
  logic last_d_q, last_d_d;

  always_comb begin
    win_d = 1'b0;
    unique case (1'b1)
      port.f_req && port.d_req:   win_d = ~last_d_q;
      port.f_req && !port.d_req:  win_d = 1'b0;
      !port.f_req && port.d_req:  win_d = 1'b1;
      default:                    win_d = 1'b0;
    endcase
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && req_any)
      last_d_d = win_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_d_q <= 1'b1;
    else          last_d_q <= last_d_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d_nx;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any) state_d = CMD;
      CMD:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request inputs are only looked at in IDLE; memory sees the latch.
  always_comb begin
    gnt_d_nx = gnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    if (state_q == IDLE && req_any) begin
      gnt_d_nx = win_d;
      addr_d   = win_d ? port.d_addr[ADDR_W+1:2]
                       : port.f_addr[ADDR_W+1:2];
      we_d     = win_d & port.d_we;
      wdata_d  = win_d ? port.d_wdata : '0;
    end
  end

  always_comb begin
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    if (resp && !gnt_q)
      f_rdata_d = mem_rdata;
    if (resp && gnt_q)
      d_rdata_d = we_q ? '0 : mem_rdata;
  end

  always_comb begin
    mem_en       = (state_q == CMD);
    mem_we       = (state_q == CMD) & we_q & gnt_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    busy         = (state_q != IDLE);
    gnt_d        = gnt_q;
    port.f_ack   = resp & ~gnt_q;
    port.d_ack   = resp & gnt_q;
    port.f_rdata = f_rdata_d;
    port.d_rdata = d_rdata_d;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous word-memory model.
// Expected values are hand-computed from the port addresses and preloads.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        gnt_d;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter_if #(.DATA_W(32)) bus ();

  mem_port_arbiter #(
    .DATA_W(32),
    .ADDR_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .port      (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .gnt_d     (gnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  bit   [255:0] written;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'd5:    return 32'hDEADBEEF;
      8'd0:    return 32'h11111111;
      8'd255:  return 32'h22222222;
      default: return {24'h0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? mem[mem_addr]
                                     : init_val(mem_addr);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic exp_d;

  initial begin
    reset_n     = 1'b0;
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt_d", 32'(gnt_d), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_f_ack", 32'(bus.f_ack), 0);
    chk("rst_d_ack", 32'(bus.d_ack), 0);
    chk("rst_f_rdata", bus.f_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    reset_n    = 1'b1;

    // Fetch word 5
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h14;
    @(negedge clk);
    chk("f_cmd_en", 32'(mem_en), 1);
    chk("f_cmd_addr", 32'(mem_addr), 5);
    chk("f_cmd_we", 32'(mem_we), 0);
    chk("f_cmd_busy", 32'(busy), 1);
    chk("f_cmd_ack", 32'(bus.f_ack), 0);
    @(negedge clk);
    chk("f_resp_ack", 32'(bus.f_ack), 1);
    chk("f_resp_data", bus.f_rdata, 32'hDEADBEEF);
    chk("f_resp_dack", 32'(bus.d_ack), 0);
    chk("f_resp_en", 32'(mem_en), 0);
    bus.f_req = 1'b0;
    @(negedge clk);
    chk("f_idle_busy", 32'(busy), 0);
    chk("f_idle_ack", 32'(bus.f_ack), 0);
    chk("f_hold_data", bus.f_rdata, 32'hDEADBEEF);

    // Store word 8
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'h12345678;
    @(negedge clk);
    chk("st_cmd_en", 32'(mem_en), 1);
    chk("st_cmd_we", 32'(mem_we), 1);
    chk("st_cmd_addr", 32'(mem_addr), 8);
    chk("st_cmd_wdata", mem_wdata, 32'h12345678);
    chk("st_cmd_gnt", 32'(gnt_d), 1);
    @(negedge clk);
    chk("st_ack", 32'(bus.d_ack), 1);
    chk("st_rdata0", bus.d_rdata, 0);
    chk("st_fack", 32'(bus.f_ack), 0);
    bus.d_we = 1'b0;
    @(negedge clk);
    chk("ld_idle_busy", 32'(busy), 0);
    chk("ld_idle_ack", 32'(bus.d_ack), 0);
    @(negedge clk);
    chk("ld_cmd_en", 32'(mem_en), 1);
    chk("ld_cmd_we", 32'(mem_we), 0);
    chk("ld_cmd_addr", 32'(mem_addr), 8);
    @(negedge clk);
    chk("ld_ack", 32'(bus.d_ack), 1);
    chk("ld_data", bus.d_rdata, 32'h12345678);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("ld_done_busy", 32'(busy), 0);

    // Continuous contention; last grant was D
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h14;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_FETCH_PRIO_EN
      exp_d = 1'b0;
`else
      exp_d = k[0];
`endif
      @(negedge clk);
      chk($sformatf("rr%0d_gnt", k), 32'(gnt_d), 32'(exp_d));
      chk($sformatf("rr%0d_en", k), 32'(mem_en), 1);
      @(negedge clk);
      chk($sformatf("rr%0d_fack", k), 32'(bus.f_ack), 32'(!exp_d));
      chk($sformatf("rr%0d_dack", k), 32'(bus.d_ack), 32'(exp_d));
      if (exp_d)
        chk($sformatf("rr%0d_dd", k), bus.d_rdata, 32'h12345678);
      else
        chk($sformatf("rr%0d_fd", k), bus.f_rdata, 32'hDEADBEEF);
      @(negedge clk);
      chk($sformatf("rr%0d_idle", k), 32'(busy), 0);
    end

    // Reset in the CMD cycle of a store
    bus.f_req   = 1'b0;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h40;
    bus.d_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("ar_cmd_gnt", 32'(gnt_d), 1);
    chk("ar_cmd_we", 32'(mem_we), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_en0", 32'(mem_en), 0);
    chk("ar_we0", 32'(mem_we), 0);
    chk("ar_busy0", 32'(busy), 0);
    chk("ar_gnt0", 32'(gnt_d), 0);
    chk("ar_dack0", 32'(bus.d_ack), 0);
    chk("ar_frd0", bus.f_rdata, 0);
    chk("ar_drd0", bus.d_rdata, 0);
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h14;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    @(negedge clk);
    chk("ar_hold_dack", 32'(bus.d_ack), 0);
    chk("ar_hold_busy", 32'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ar_first_gnt", 32'(gnt_d), 0);
    chk("ar_first_addr", 32'(mem_addr), 5);
    @(negedge clk);
    chk("ar_first_fack", 32'(bus.f_ack), 1);
    chk("ar_first_dack", 32'(bus.d_ack), 0);
    chk("ar_first_data", bus.f_rdata, 32'hDEADBEEF);
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("ar_idle", 32'(busy), 0);

    // Address wrap and low-bit drop
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h403;
    @(negedge clk);
    chk("wrap_f_addr", 32'(mem_addr), 0);
    @(negedge clk);
    chk("wrap_f_ack", 32'(bus.f_ack), 1);
    chk("wrap_f_data", bus.f_rdata, 32'h11111111);
    bus.f_req = 1'b0;
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h3FC;
    @(negedge clk);
    chk("wrap_d_addr", 32'(mem_addr), 255);
    chk("wrap_d_gnt", 32'(gnt_d), 1);
    @(negedge clk);
    chk("wrap_d_ack", 32'(bus.d_ack), 1);
    chk("wrap_d_data", bus.d_rdata, 32'h22222222);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("wrap_idle", 32'(busy), 0);
    chk("wrap_d_hold", bus.d_rdata, 32'h22222222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
